// File: rtl/cva5_fifo_skid.sv
// cva5_fifo_skid: two-entry skid buffer between a FIFO head and its consumer.
// The FIFO pop never depends on out_ready; a saturating counter tracks output handshakes.
module cva5_fifo_skid #(
    parameter type DATA_TYPE = logic [31:0],
    parameter int  CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_valid,
    input  DATA_TYPE             fifo_data,
    output logic                 fifo_pop,
    output logic                 out_valid,
    output DATA_TYPE             out_data,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] transfer_count
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t               state_q, state_d;
    DATA_TYPE             main_q, main_d, skid_q, skid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 xfer;

    // Gated by rst so the FIFO is never drained while the buffer is held in reset.
    assign fifo_pop       = rst & fifo_valid & ~flush & (state_q != TWO);
    assign out_valid      = state_q != EMPTY;
    assign out_data       = main_q;
    assign occupancy      = state_q;
    assign transfer_count = cnt_q;
    assign xfer           = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = (xfer && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (fifo_pop) begin
                        main_d  = fifo_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (fifo_pop && xfer) begin
                        main_d = fifo_data;
                    end else if (fifo_pop) begin
                        skid_d  = fifo_data;
                        state_d = TWO;
                    end else if (xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (xfer) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: doc/cva5_fifo_skid.md
CVA5_FIFO_SKID -- requirements
Module: cva5_fifo_skid

Interface
REQ-001 SHALL have parameter DATA_TYPE, default logic [31:0]; this is the entry type carried from the FIFO head to the consumer.
REQ-002 SHALL have parameter CNT_WIDTH, default 16; this is the width of the transfer statistic counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 fifo_valid  in  1  upstream FIFO head holds a valid entry.
REQ-007 fifo_data  in  DATA_TYPE  upstream FIFO head entry.
REQ-008 fifo_pop  out  1  dequeues the FIFO head this cycle.
REQ-009 out_valid  out  1  out_data is valid.
REQ-010 out_data  out  DATA_TYPE  entry presented to the consumer.
REQ-011 out_ready  in  1  consumer accepts out_data this cycle.
REQ-012 flush  in  1  discards all held entries.
REQ-013 occupancy  out  2  number of held entries (0..2).
REQ-014 transfer_count  out  CNT_WIDTH  saturating count of completed output handshakes.

Function
REQ-015 SHALL hold at most two entries: a main register driving out_data, and a skid register.
REQ-016 SHALL implement the states EMPTY, ONE and TWO, with occupancy equal to 0, 1 and 2 respectively.
REQ-017 SHALL drive fifo_pop = fifo_valid & ~flush & (state != TWO), combinationally.
REQ-018 fifo_pop SHALL NOT depend on out_ready, so that no combinational ready path reaches the FIFO.
REQ-019 SHALL drive out_valid = (state != EMPTY) and out_data = main register; both are registered.
REQ-020 SHALL define xfer = out_valid & out_ready.
REQ-021 EMPTY: on pop, main <= fifo_data and the next state is ONE; otherwise the state remains EMPTY.
REQ-022 ONE, pop & xfer: main <= fifo_data; the state remains ONE.
REQ-023 ONE, pop & ~xfer: skid <= fifo_data; the next state is TWO.
REQ-024 ONE, ~pop & xfer: the next state is EMPTY.
REQ-025 ONE, ~pop & ~xfer: hold the state and the registers.
REQ-026 TWO, xfer: main <= skid; the next state is ONE.
REQ-027 TWO, ~xfer: hold the state and the registers.
REQ-028 Latency SHALL be 1 cycle from a pop to the corresponding out_valid/out_data.
REQ-029 Sustained throughput SHALL be 1 entry per cycle in state ONE while out_ready is held high.
REQ-030 Output order SHALL equal pop order, with no loss or duplication outside a flush.
REQ-031 While out_valid = 1 and out_ready = 0, out_data SHALL remain stable.
REQ-032 Flush SHALL take priority over all other transitions: the next state is EMPTY, fifo_pop = 0, and held entries are dropped.
REQ-033 An xfer coinciding with a flush SHALL still complete and be counted, because the consumer sampled it.
REQ-034 transfer_count SHALL increment by 1 on each xfer and saturate at 2^CNT_WIDTH-1 without wrap-around.
REQ-035 flush SHALL NOT clear transfer_count.
REQ-036 out_ready asserted while out_valid = 0 SHALL have no effect.
REQ-037 fifo_data SHALL be sampled only on cycles with fifo_pop = 1; its value at other times is don't-care.

Reset
REQ-038 When rst = 0, asynchronously: state = EMPTY, out_valid = 0, occupancy = 0, transfer_count = 0, and the main and skid registers = 0.
REQ-039 fifo_pop SHALL be 0 while rst = 0.
REQ-040 Reset asserted mid-operation SHALL drop held entries without producing an xfer.
REQ-041 The first pop SHALL be possible in the first rising edge after rst deasserts.

Verification
REQ-042 Reset/idle: hold rst = 0, then release with fifo_valid = 0 -> out_valid = 0, occupancy = 0, transfer_count = 0, fifo_pop = 0.
REQ-043 Streaming: fifo_valid = 1 with data 1,2,3,4 on consecutive cycles and out_ready = 1 -> out_data 1,2,3,4 on consecutive cycles starting 1 cycle after the first pop; occupancy = 1 throughout; transfer_count = 4.
REQ-044 Backpressure: push A and B, out_ready = 0 for 5 cycles -> occupancy = 2, fifo_pop = 0, out_data = A held stable; release out_ready -> A then B, then out_valid = 0.
REQ-045 Flush in TWO with out_ready = 1 the same cycle -> A counted (transfer_count +1), B dropped, next cycle out_valid = 0 and fifo_pop = 0 during the flush cycle.
REQ-046 Saturation: CNT_WIDTH = 4 with 20 transfers -> transfer_count = 15 and it stays 15.
REQ-047 Async reset pulse mid-stream in state TWO -> outputs clear immediately without waiting for clk; the stream restarts cleanly after release.
